// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Purpose : Shared constants and helpers for the parameterised FIFO slice.
//           Holds the default data width and depth and a function that sizes
//           the read/write pointers. No types are shared between files.
// Contents:
//    DEFAULT_WIDTH - default data word width in bits
//    DEFAULT_DEPTH - default number of entries (power of two)
//    ptr_width()   - pointer width for a given depth: address bits plus one
//                    wrap bit used to tell full from empty
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 16;

   // The extra MSB toggles on every pass through storage, so equal low bits
   // with different MSBs means the write side is a whole lap ahead.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Purpose : Storage array for fifo_param. One synchronous write port and one
//           asynchronous read port. The array has no reset so that it maps
//           onto plain RAM/register-file resources.
// Ports   :
//    clk      in   sole clock, writes on rising edge
//    wr_en    in   write strobe (already qualified by the controller)
//    wr_addr  in   AW   write address
//    wr_data  in   WIDTH write data
//    rd_addr  in   AW   read address
//    rd_data  out  WIDTH combinational read of rd_addr
// -----------------------------------------------------------------------------
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: only the controller decides whether a write is accepted,
   // so a refused write never reaches the array.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Asynchronous read lets the controller either register the word (standard
   // mode) or present the head directly (first-word-fall-through).
   assign rd_data = mem[rd_addr];

endmodule : fifo_mem

// File: rtl/fifo_param.sv
// -----------------------------------------------------------------------------
// fifo_param
// Purpose : Synchronous parameterised FIFO with occupancy count, almost-full /
//           almost-empty thresholds, sticky overflow/underflow flags and a
//           selectable read mode (registered read or first-word-fall-through).
// Parameters:
//    WIDTH    data word width (>=1)
//    DEPTH    number of entries (power of two, >=2)
//    AF_LEVEL count at or above which almost_full asserts
//    AE_LEVEL count at or below which almost_empty asserts
//    FWFT     0 = registered read, 1 = first-word-fall-through
// Ports   :
//    clk          in   sole clock
//    rst          in   asynchronous active-low reset
//    wr_e         in   write request
//    wr_data      in   WIDTH write data
//    rd_e         in   read request
//    rd_data      out  WIDTH read data
//    busy         out  FIFO full, writes refused
//    empty        out  FIFO holds no entries
//    almost_full  out  count >= AF_LEVEL
//    almost_empty out  count <= AE_LEVEL
//    count        out  number of stored entries, 0..DEPTH
//    overflow     out  sticky: a write was refused
//    underflow    out  sticky: a read was refused
//    clr_err      in   synchronous clear of overflow/underflow
// -----------------------------------------------------------------------------
module fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_e,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_e,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   busy,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   clr_err
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
   localparam logic [PW-1:0] AF_CNT   = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_CNT   = PW'(AE_LEVEL);

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;
   logic [WIDTH-1:0] mem_rd_data;

   // Status is a pure decode of the registered count, so it changes on the
   // same edge as count and never lags it.
   assign busy         = (count == FULL_CNT);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_CNT);
   assign almost_empty = (count <= AE_CNT);

   // An operation is accepted only when the current state allows it. When
   // full, a simultaneous read still goes through but the write is refused;
   // when empty, the write goes through but the read is refused.
   assign wr_ok = wr_e & ~busy;
   assign rd_ok = rd_e & ~empty;

   // Pointers and count move only on accepted operations. Count holds on a
   // simultaneous accepted read+write since occupancy does not change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags. A refusal in the same cycle as clr_err keeps the
   // flag set so that no error event can be lost by a concurrent clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_e && busy) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (rd_e && empty) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (mem_rd_data)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         // The head entry is always visible; forcing zero while empty hides
         // stale storage contents, which are never cleared.
         assign rd_data = empty ? '0 : mem_rd_data;
      end else begin : g_std
         logic [WIDTH-1:0] rd_q;

         // Capture the head word on the edge that pops it and hold it until
         // the next accepted read; refused reads leave it untouched.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               rd_q <= '0;
            end else if (rd_ok) begin
               rd_q <= mem_rd_data;
            end
         end

         assign rd_data = rd_q;
      end
   endgenerate

endmodule : fifo_param

// File: tb/tb_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_param
// Purpose : Directed self-checking bench for fifo_param. Three instances:
//    a : WIDTH=2, DEPTH=4,  FWFT=0 (registered read)
//    b : WIDTH=2, DEPTH=4,  FWFT=1
//    c : WIDTH=8, DEPTH=16, FWFT=1 (default thresholds 14 / 2)
// All instances share clk and the active-low reset.
// -----------------------------------------------------------------------------
module tb_fifo_param;

   logic clk;
   logic rst;

   int checks   = 0;
   int failures = 0;

   // Instance a signals
   logic       a_wr_e, a_rd_e, a_clr_err;
   logic [1:0] a_wr_data, a_rd_data;
   logic       a_busy, a_empty, a_af, a_ae, a_ovf, a_unf;
   logic [2:0] a_count;

   // Instance b signals
   logic       b_wr_e, b_rd_e, b_clr_err;
   logic [1:0] b_wr_data, b_rd_data;
   logic       b_busy, b_empty, b_af, b_ae, b_ovf, b_unf;
   logic [2:0] b_count;

   // Instance c signals
   logic       c_wr_e, c_rd_e, c_clr_err;
   logic [7:0] c_wr_data, c_rd_data;
   logic       c_busy, c_empty, c_af, c_ae, c_ovf, c_unf;
   logic [4:0] c_count;

   fifo_param #(.WIDTH(2), .DEPTH(4), .FWFT(0)) dut_a (
      .clk (clk), .rst (rst),
      .wr_e (a_wr_e), .wr_data (a_wr_data), .rd_e (a_rd_e), .rd_data (a_rd_data),
      .busy (a_busy), .empty (a_empty), .almost_full (a_af), .almost_empty (a_ae),
      .count (a_count), .overflow (a_ovf), .underflow (a_unf), .clr_err (a_clr_err)
   );

   fifo_param #(.WIDTH(2), .DEPTH(4), .FWFT(1)) dut_b (
      .clk (clk), .rst (rst),
      .wr_e (b_wr_e), .wr_data (b_wr_data), .rd_e (b_rd_e), .rd_data (b_rd_data),
      .busy (b_busy), .empty (b_empty), .almost_full (b_af), .almost_empty (b_ae),
      .count (b_count), .overflow (b_ovf), .underflow (b_unf), .clr_err (b_clr_err)
   );

   fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) dut_c (
      .clk (clk), .rst (rst),
      .wr_e (c_wr_e), .wr_data (c_wr_data), .rd_e (c_rd_e), .rd_data (c_rd_data),
      .busy (c_busy), .empty (c_empty), .almost_full (c_af), .almost_empty (c_ae),
      .count (c_count), .overflow (c_ovf), .underflow (c_unf), .clr_err (c_clr_err)
   );

   // 10 ns clock; inputs change and outputs are sampled 1 ns after the edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (a_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", a_count); end
      checks++; if (a_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", a_empty); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", a_busy); end
      checks++; if (a_ae !== 1'b1) begin failures++; $display("[TB] FAIL reset_almost_empty got=%b exp=1", a_ae); end
      checks++; if (a_af !== 1'b0) begin failures++; $display("[TB] FAIL reset_almost_full got=%b exp=0", a_af); end
      checks++; if (a_rd_data !== 2'd0) begin failures++; $display("[TB] FAIL reset_rd_data got=%0d exp=0", a_rd_data); end
      checks++; if ({a_ovf, a_unf} !== 2'b00) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=00", {a_ovf, a_unf}); end
      checks++; if (b_rd_data !== 2'd0) begin failures++; $display("[TB] FAIL reset_fwft_rd_data got=%0d exp=0", b_rd_data); end
      checks++; if (c_count !== 5'd0) begin failures++; $display("[TB] FAIL reset_c_count got=%0d exp=0", c_count); end
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      a_wr_e = 1'b1; a_wr_data = 2'b10;
      tick();
      a_wr_e = 1'b0;
      checks++; if (a_count !== 3'd1) begin failures++; $display("[TB] FAIL basic_count_after_write got=%0d exp=1", a_count); end
      checks++; if (a_empty !== 1'b0) begin failures++; $display("[TB] FAIL basic_empty_after_write got=%b exp=0", a_empty); end
      repeat (10) tick();
      a_rd_e = 1'b1;
      tick();
      a_rd_e = 1'b0;
      checks++; if (a_rd_data !== 2'b10) begin failures++; $display("[TB] FAIL basic_rd_data got=%0d exp=2", a_rd_data); end
      checks++; if (a_empty !== 1'b1) begin failures++; $display("[TB] FAIL basic_empty got=%b exp=1", a_empty); end
      checks++; if (a_count !== 3'd0) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=0", a_count); end
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 4; k++) begin
         a_wr_e = 1'b1; a_wr_data = 2'(k);
         tick();
      end
      checks++; if (a_busy !== 1'b1) begin failures++; $display("[TB] FAIL ovf_busy_full got=%b exp=1", a_busy); end
      checks++; if (a_af !== 1'b1) begin failures++; $display("[TB] FAIL ovf_almost_full got=%b exp=1", a_af); end
      checks++; if (a_ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_flag_before got=%b exp=0", a_ovf); end
      a_wr_data = 2'd2;
      tick();
      a_wr_e = 1'b0;
      checks++; if (a_busy !== 1'b1) begin failures++; $display("[TB] FAIL ovf_busy got=%b exp=1", a_busy); end
      checks++; if (a_ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=1", a_ovf); end
      checks++; if (a_count !== 3'd4) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=4", a_count); end
      for (int k = 0; k < 4; k++) begin
         a_rd_e = 1'b1;
         tick();
         checks++; if (a_rd_data !== 2'(k)) begin failures++; $display("[TB] FAIL ovf_drain_%0d got=%0d exp=%0d", k, a_rd_data, k); end
      end
      a_rd_e = 1'b0;
      checks++; if (a_empty !== 1'b1) begin failures++; $display("[TB] FAIL ovf_drain_empty got=%b exp=1", a_empty); end
      a_clr_err = 1'b1;
      tick();
      a_clr_err = 1'b0;
      checks++; if (a_ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%b exp=0", a_ovf); end
   endtask

   task automatic test_underflow();
      a_rd_e = 1'b1;
      tick();
      a_rd_e = 1'b0;
      checks++; if (a_unf !== 1'b1) begin failures++; $display("[TB] FAIL unf_flag got=%b exp=1", a_unf); end
      checks++; if (a_rd_data !== 2'd3) begin failures++; $display("[TB] FAIL unf_rd_data_hold got=%0d exp=3", a_rd_data); end
      checks++; if (a_count !== 3'd0) begin failures++; $display("[TB] FAIL unf_count got=%0d exp=0", a_count); end
      a_clr_err = 1'b1;
      tick();
      a_clr_err = 1'b0;
      checks++; if (a_unf !== 1'b0) begin failures++; $display("[TB] FAIL unf_clear got=%b exp=0", a_unf); end
      // Refusal coinciding with clear: the set wins.
      a_rd_e = 1'b1; a_clr_err = 1'b1;
      tick();
      a_rd_e = 1'b0; a_clr_err = 1'b0;
      checks++; if (a_unf !== 1'b1) begin failures++; $display("[TB] FAIL unf_set_wins got=%b exp=1", a_unf); end
      a_clr_err = 1'b1;
      tick();
      a_clr_err = 1'b0;
      checks++; if (a_unf !== 1'b0) begin failures++; $display("[TB] FAIL unf_clear2 got=%b exp=0", a_unf); end
   endtask

   task automatic test_simultaneous();
      logic [1:0] fill [4];
      logic [1:0] tail [3];
      fill[0] = 2'd3; fill[1] = 2'd0; fill[2] = 2'd1; fill[3] = 2'd2;
      tail[0] = 2'd0; tail[1] = 2'd1; tail[2] = 2'd2;
      for (int k = 0; k < 4; k++) begin
         a_wr_e = 1'b1; a_wr_data = fill[k];
         tick();
      end
      // Full: read accepted, write of 3 refused.
      a_wr_data = 2'd3; a_rd_e = 1'b1;
      tick();
      a_wr_e = 1'b0; a_rd_e = 1'b0;
      checks++; if (a_count !== 3'd3) begin failures++; $display("[TB] FAIL sim_full_count got=%0d exp=3", a_count); end
      checks++; if (a_ovf !== 1'b1) begin failures++; $display("[TB] FAIL sim_full_overflow got=%b exp=1", a_ovf); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("[TB] FAIL sim_full_busy got=%b exp=0", a_busy); end
      checks++; if (a_rd_data !== 2'd3) begin failures++; $display("[TB] FAIL sim_full_rd_data got=%0d exp=3", a_rd_data); end
      for (int k = 0; k < 3; k++) begin
         a_rd_e = 1'b1;
         tick();
         checks++; if (a_rd_data !== tail[k]) begin failures++; $display("[TB] FAIL sim_drain_%0d got=%0d exp=%0d", k, a_rd_data, tail[k]); end
      end
      a_rd_e = 1'b0;
      a_clr_err = 1'b1;
      tick();
      a_clr_err = 1'b0;
      // Empty: write accepted, read refused.
      a_wr_e = 1'b1; a_wr_data = 2'd1; a_rd_e = 1'b1;
      tick();
      a_wr_e = 1'b0; a_rd_e = 1'b0;
      checks++; if (a_count !== 3'd1) begin failures++; $display("[TB] FAIL sim_empty_count got=%0d exp=1", a_count); end
      checks++; if (a_unf !== 1'b1) begin failures++; $display("[TB] FAIL sim_empty_underflow got=%b exp=1", a_unf); end
      checks++; if (a_rd_data !== 2'd2) begin failures++; $display("[TB] FAIL sim_empty_rd_hold got=%0d exp=2", a_rd_data); end
      a_rd_e = 1'b1;
      tick();
      a_rd_e = 1'b0;
      checks++; if (a_rd_data !== 2'd1) begin failures++; $display("[TB] FAIL sim_empty_pop got=%0d exp=1", a_rd_data); end
      a_clr_err = 1'b1;
      tick();
      a_clr_err = 1'b0;
   endtask

   task automatic test_fwft();
      checks++; if (b_rd_data !== 2'd0) begin failures++; $display("[TB] FAIL fwft_empty_zero got=%0d exp=0", b_rd_data); end
      b_wr_e = 1'b1; b_wr_data = 2'b11;
      tick();
      b_wr_data = 2'b01;
      checks++; if (b_rd_data !== 2'b11) begin failures++; $display("[TB] FAIL fwft_fall_through got=%0d exp=3", b_rd_data); end
      checks++; if (b_count !== 3'd1) begin failures++; $display("[TB] FAIL fwft_count got=%0d exp=1", b_count); end
      tick();
      b_wr_e = 1'b0;
      checks++; if (b_rd_data !== 2'b11) begin failures++; $display("[TB] FAIL fwft_head_hold got=%0d exp=3", b_rd_data); end
      b_rd_e = 1'b1;
      tick();
      checks++; if (b_rd_data !== 2'b01) begin failures++; $display("[TB] FAIL fwft_advance got=%0d exp=1", b_rd_data); end
      tick();
      b_rd_e = 1'b0;
      checks++; if (b_empty !== 1'b1) begin failures++; $display("[TB] FAIL fwft_empty got=%b exp=1", b_empty); end
      checks++; if (b_rd_data !== 2'd0) begin failures++; $display("[TB] FAIL fwft_empty_zero2 got=%0d exp=0", b_rd_data); end
   endtask

   task automatic test_wrap();
      int widx;
      int ridx;
      for (int k = 0; k < 14; k++) begin
         c_wr_e = 1'b1; c_wr_data = 8'(8'h40 + k);
         tick();
         if (k == 12) begin
            checks++; if (c_count !== 5'd13) begin failures++; $display("[TB] FAIL wrap_count13 got=%0d exp=13", c_count); end
            checks++; if (c_af !== 1'b0) begin failures++; $display("[TB] FAIL wrap_af_at13 got=%b exp=0", c_af); end
         end
      end
      c_wr_e = 1'b0;
      checks++; if (c_count !== 5'd14) begin failures++; $display("[TB] FAIL wrap_count14 got=%0d exp=14", c_count); end
      checks++; if (c_af !== 1'b1) begin failures++; $display("[TB] FAIL wrap_af_at14 got=%b exp=1", c_af); end
      checks++; if (c_rd_data !== 8'h40) begin failures++; $display("[TB] FAIL wrap_head0 got=%0h exp=40", c_rd_data); end
      for (int k = 0; k < 12; k++) begin
         c_rd_e = 1'b1;
         tick();
         if (k == 10) begin
            checks++; if (c_count !== 5'd3) begin failures++; $display("[TB] FAIL wrap_count3 got=%0d exp=3", c_count); end
            checks++; if (c_ae !== 1'b0) begin failures++; $display("[TB] FAIL wrap_ae_at3 got=%b exp=0", c_ae); end
         end
      end
      c_rd_e = 1'b0;
      checks++; if (c_count !== 5'd2) begin failures++; $display("[TB] FAIL wrap_count2 got=%0d exp=2", c_count); end
      checks++; if (c_ae !== 1'b1) begin failures++; $display("[TB] FAIL wrap_ae_at2 got=%b exp=1", c_ae); end
      checks++; if (c_rd_data !== 8'h4c) begin failures++; $display("[TB] FAIL wrap_head12 got=%0h exp=4c", c_rd_data); end
      widx = 14;
      ridx = 12;
      // Streaming write+read carries both pointers through several laps.
      for (int k = 0; k < 40; k++) begin
         c_wr_e = 1'b1; c_rd_e = 1'b1; c_wr_data = 8'(8'h40 + widx);
         tick();
         widx++;
         ridx++;
         checks++; if (c_count !== 5'd2) begin failures++; $display("[TB] FAIL wrap_stream_count_%0d got=%0d exp=2", k, c_count); end
         checks++; if (c_rd_data !== 8'(8'h40 + ridx)) begin failures++; $display("[TB] FAIL wrap_stream_head_%0d got=%0h exp=%0h", k, c_rd_data, 8'(8'h40 + ridx)); end
      end
      c_wr_e = 1'b0;
      tick();
      checks++; if (c_rd_data !== 8'(8'h40 + ridx + 1)) begin failures++; $display("[TB] FAIL wrap_drain1 got=%0h exp=%0h", c_rd_data, 8'(8'h40 + ridx + 1)); end
      checks++; if (c_count !== 5'd1) begin failures++; $display("[TB] FAIL wrap_drain1_count got=%0d exp=1", c_count); end
      tick();
      c_rd_e = 1'b0;
      checks++; if (c_count !== 5'd0) begin failures++; $display("[TB] FAIL wrap_drain2_count got=%0d exp=0", c_count); end
      checks++; if (c_rd_data !== 8'h00) begin failures++; $display("[TB] FAIL wrap_drain2_zero got=%0h exp=0", c_rd_data); end
   endtask

   task automatic test_reset_mid();
      a_rd_e = 1'b1;
      tick();
      a_rd_e = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a_wr_e = 1'b1; a_wr_data = 2'(k + 1);
         tick();
      end
      a_wr_e = 1'b1; a_wr_data = 2'd3;
      checks++; if (a_count !== 3'd3) begin failures++; $display("[TB] FAIL rstmid_pre_count got=%0d exp=3", a_count); end
      checks++; if (a_unf !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pre_unf got=%b exp=1", a_unf); end
      // Reset lands mid-cycle; outputs must clear before the next edge.
      #2;
      rst = 1'b0;
      #1;
      checks++; if (a_count !== 3'd0) begin failures++; $display("[TB] FAIL rstmid_count got=%0d exp=0", a_count); end
      checks++; if ({a_empty, a_busy, a_ae, a_af} !== 4'b1010) begin failures++; $display("[TB] FAIL rstmid_status got=%b exp=1010", {a_empty, a_busy, a_ae, a_af}); end
      checks++; if (a_rd_data !== 2'd0) begin failures++; $display("[TB] FAIL rstmid_rd_data got=%0d exp=0", a_rd_data); end
      checks++; if ({a_ovf, a_unf} !== 2'b00) begin failures++; $display("[TB] FAIL rstmid_flags got=%b exp=00", {a_ovf, a_unf}); end
      a_wr_e = 1'b0;
      tick();
      checks++; if (a_count !== 3'd0) begin failures++; $display("[TB] FAIL rstmid_hold_count got=%0d exp=0", a_count); end
      rst = 1'b1;
      tick();
      a_wr_e = 1'b1; a_wr_data = 2'b01;
      tick();
      a_wr_e = 1'b0;
      checks++; if (a_count !== 3'd1) begin failures++; $display("[TB] FAIL rstmid_after_write got=%0d exp=1", a_count); end
      a_rd_e = 1'b1;
      tick();
      a_rd_e = 1'b0;
      checks++; if (a_rd_data !== 2'b01) begin failures++; $display("[TB] FAIL rstmid_after_read got=%0d exp=1", a_rd_data); end
      checks++; if (a_empty !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_after_empty got=%b exp=1", a_empty); end
   endtask

   // Single sequencer: every scenario runs in order, then the summary.
   initial begin
      rst = 1'b0;
      a_wr_e = 1'b0; a_rd_e = 1'b0; a_clr_err = 1'b0; a_wr_data = '0;
      b_wr_e = 1'b0; b_rd_e = 1'b0; b_clr_err = 1'b0; b_wr_data = '0;
      c_wr_e = 1'b0; c_rd_e = 1'b0; c_clr_err = 1'b0; c_wr_data = '0;
      $display("[TB] starting fifo_param bench");
      test_reset();
      test_basic();
      test_overflow();
      test_underflow();
      test_simultaneous();
      test_fwft();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fifo_param
